// File: rtl/btn_cond_pkg.sv
// Shared types and default timing for the push-button conditioning stage.
// Optional feature macro used by this slice: BTN_COND_REPEAT_EN.
package btn_cond_pkg;

  typedef enum logic [1:0] {ST_LO, WAIT_HI, ST_HI, WAIT_LO} deb_state_t;

  localparam int unsigned DEB_CYCLES_DEFAULT    = 1_250_000;
  localparam int unsigned REPEAT_CYCLES_DEFAULT = 62_500_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce FSM, registered pulses.
// BTN_COND_REPEAT_EN adds auto-repeat press pulses while the button is held.
module btn_debounce
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_DEFAULT
`ifdef BTN_COND_REPEAT_EN
  , parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

`ifdef BTN_COND_REPEAT_EN
  localparam int unsigned CNT_W = $clog2(max_u(DEBOUNCE_CYCLES, REPEAT_CYCLES));
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`else
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
`endif
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             s;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  assign s = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      state_q   <= ST_LO;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], raw};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_LO: begin
        cnt_d = '0;
        if (s) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_HI;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end else begin
`ifdef BTN_COND_REPEAT_EN
          if (cnt_q == RPT_LAST) begin
            press_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          cnt_d = '0;
`endif
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = ST_LO;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// N_BTN independent button channels: clean level plus press/release pulses.
// BTN_COND_REPEAT_EN enables auto-repeat presses every REPEAT_CYCLES while held.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_timing
    $error("btn_conditioner: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_COND_REPEAT_EN
      , .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
    ) u_debounce (
      .clk          (clk),
      .reset_n      (reset_n),
      .raw          (btn_raw[i]),
      .level        (btn_level[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8).
// Honours BTN_COND_REPEAT_EN for the auto-repeat expectations.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN(4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One active edge, then return to the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic bounce [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic exp_p;

    reset_n = 1'b0;
    btn_raw = 4'h0;
    @(negedge clk);
    tick();
    tick();
    check("rst_level",   32'(btn_level),   32'h0);
    check("rst_press",   32'(btn_press),   32'h0);
    check("rst_release", 32'(btn_release), 32'h0);
    reset_n = 1'b1;
    tick();

    // Channel 0 press latency: raw first sampled at edge 0.
    btn_raw[0] = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      tick();
      check($sformatf("t2_press_e%0d", e), 32'(btn_press[0]), 32'(e == 6));
      check($sformatf("t2_level_e%0d", e), 32'(btn_level[0]), 32'(e >= 6));
    end

    // Asynchronous reset while level is high, checked before any clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_level", 32'(btn_level), 32'h0);
    check("async_rst_press", 32'(btn_press), 32'h0);
    btn_raw = 4'h0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Channel 1 bounce must never qualify.
    for (int i = 0; i < 12; i++) begin
      btn_raw[1] = bounce[i];
      tick();
      check($sformatf("t3_quiet_%0d", i),
            32'({btn_press[1], btn_release[1], btn_level[1]}), 32'h0);
    end

    // Channel 2 release latency and pulse exclusivity.
    btn_raw[2] = 1'b1;
    repeat (10) tick();
    check("t4_level_held", 32'(btn_level[2]), 32'h1);
    btn_raw[2] = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      tick();
      check($sformatf("t4_release_e%0d", e), 32'(btn_release[2]), 32'(e == 6));
      check($sformatf("t4_level_e%0d", e),   32'(btn_level[2]),   32'(e < 6));
      check($sformatf("t4_excl_e%0d", e),    32'(btn_press[2] & btn_release[2]), 32'h0);
    end

    // All channels together.
    btn_raw = 4'hF;
    for (int e = 0; e <= 8; e++) begin
      tick();
      check($sformatf("t5_press_e%0d", e), 32'(btn_press), (e == 6) ? 32'hF : 32'h0);
    end
    btn_raw = 4'h0;
    repeat (12) tick();
    check("t5_all_released", 32'(btn_level), 32'h0);

    // Channel 3 held: auto-repeat only when the feature is built in.
    btn_raw[3] = 1'b1;
    for (int e = 0; e <= 24; e++) begin
      tick();
`ifdef BTN_COND_REPEAT_EN
      exp_p = (e == 6) || (e == 14) || (e == 22);
`else
      exp_p = (e == 6);
`endif
      check($sformatf("t6_press_e%0d", e), 32'(btn_press[3]), 32'(exp_p));
    end
    btn_raw = 4'h0;
    repeat (10) tick();
    check("t6_level_final", 32'(btn_level), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
